vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 131 +++++++++++++
 tb/tb_vram_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// VRAM port arbiter: queues CPU writes in a FIFO and interleaves them with GPU fetches.
// Optional write-starvation guard enabled by defining VRAM_ARBITER_STARVE_GUARD_EN.
module vram_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                          clk_12_5875,
  input  logic                          rst,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_WIDTH-1:0]         cpu_wr_address,
  input  logic [7:0]                    cpu_wr_data,
  input  logic                          gpu_rd_req,
  input  logic [ADDR_WIDTH-1:0]         gpu_rd_address,
  output logic                          gpu_rd_grant,
  output logic                          gpu_rd_valid,
  output logic [7:0]                    gpu_rd_data,
  output logic [ADDR_WIDTH-1:0]         vram_address,
  output logic [7:0]                    vram_wdata,
  output logic                          vram_we,
  input  logic [7:0]                    vram_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            data;
  } wr_entry_t;

  wr_entry_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] vram_address_q, vram_address_d;
  logic [7:0]            vram_wdata_q, vram_wdata_d;
  logic                  vram_we_q, vram_we_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  push, fifo_empty, force_wr, gpu_slot, wr_slot;

`ifdef VRAM_ARBITER_STARVE_GUARD_EN
  localparam int unsigned STARVE_W     = 4;
  localparam int unsigned STARVE_LIMIT = 8;
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_wr = (starve_q == STARVE_W'(STARVE_LIMIT));

  // Counts cycles a queued write was passed over; clears on any write slot or empty FIFO.
  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || wr_slot) begin
      starve_d = '0;
    end else if (!force_wr) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_wr = 1'b0;
`endif

  // Entries are only visible to the arbiter once count_q includes them, so no bypass.
  assign cpu_wr_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign push         = cpu_wr_valid && cpu_wr_ready;
  assign fifo_empty   = (count_q == '0);
  assign gpu_slot     = gpu_rd_req && !force_wr && !rst;
  assign wr_slot      = !gpu_slot && !fifo_empty;

  assign gpu_rd_grant = gpu_slot;
  assign gpu_rd_valid = rd_valid_q;
  assign gpu_rd_data  = vram_rdata;
  assign vram_address = vram_address_q;
  assign vram_wdata   = vram_wdata_q;
  assign vram_we      = vram_we_q;
  assign fifo_count   = count_q;

  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + CNT_W'(push) - CNT_W'(wr_slot);
    vram_address_d = vram_address_q;
    vram_wdata_d   = vram_wdata_q;
    vram_we_d      = wr_slot;
    rd_pend_d      = gpu_slot;
    rd_valid_d     = rd_pend_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (wr_slot) begin
      rd_ptr_d       = rd_ptr_q + PTR_W'(1);
      vram_address_d = mem_q[rd_ptr_q].addr;
      vram_wdata_d   = mem_q[rd_ptr_q].data;
    end else if (gpu_slot) begin
      vram_address_d = gpu_rd_address;
    end
  end

  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      vram_address_q <= '0;
      vram_wdata_q   <= '0;
      vram_we_q      <= 1'b0;
      rd_pend_q      <= 1'b0;
      rd_valid_q     <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      vram_address_q <= vram_address_d;
      vram_wdata_q   <= vram_wdata_d;
      vram_we_q      <= vram_we_d;
      rd_pend_q      <= rd_pend_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge clk_12_5875) begin
    if (push) mem_q[wr_ptr_q] <= '{addr: cpu_wr_address, data: cpu_wr_data};
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter with a behavioural synchronous VRAM.
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_wr_valid;
  logic        cpu_wr_ready;
  logic [11:0] cpu_wr_address;
  logic [7:0]  cpu_wr_data;
  logic        gpu_rd_req;
  logic [11:0] gpu_rd_address;
  logic        gpu_rd_grant;
  logic        gpu_rd_valid;
  logic [7:0]  gpu_rd_data;
  logic [11:0] vram_address;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic [7:0]  vram_rdata;
  logic [2:0]  fifo_count;

  logic [7:0]  vmem [4096];
  int          checks = 0;
  int          failures = 0;
  int          writes;
  int          nogrant;

  vram_arbiter #(.FIFO_DEPTH(4), .ADDR_WIDTH(12)) dut (
    .clk_12_5875    (clk),
    .rst            (rst),
    .cpu_wr_valid   (cpu_wr_valid),
    .cpu_wr_ready   (cpu_wr_ready),
    .cpu_wr_address (cpu_wr_address),
    .cpu_wr_data    (cpu_wr_data),
    .gpu_rd_req     (gpu_rd_req),
    .gpu_rd_address (gpu_rd_address),
    .gpu_rd_grant   (gpu_rd_grant),
    .gpu_rd_valid   (gpu_rd_valid),
    .gpu_rd_data    (gpu_rd_data),
    .vram_address   (vram_address),
    .vram_wdata     (vram_wdata),
    .vram_we        (vram_we),
    .vram_rdata     (vram_rdata),
    .fifo_count     (fifo_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous VRAM: data for the address seen at an edge appears after that edge.
  always @(posedge clk) begin
    if (vram_we) vmem[vram_address] <= vram_wdata;
    vram_rdata <= vmem[vram_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [11:0] a, input logic [7:0] d);
    cpu_wr_valid   = 1'b1;
    cpu_wr_address = a;
    cpu_wr_data    = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) vmem[i] = 8'(i);
    vmem[12'h040] = 8'h3C;
    vram_rdata     = 8'h00;
    rst            = 1'b1;
    cpu_wr_valid   = 1'b0;
    cpu_wr_address = '0;
    cpu_wr_data    = '0;
    gpu_rd_req     = 1'b1;
    gpu_rd_address = 12'h040;

    // Reset state, grant suppressed while in reset
    step();
    step();
    check("rst_grant", 32'(gpu_rd_grant), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_we", 32'(vram_we), 32'd0);
    check("rst_addr", 32'(vram_address), 32'h0);
    check("rst_wdata", 32'(vram_wdata), 32'h0);
    check("rst_valid", 32'(gpu_rd_valid), 32'd0);
    gpu_rd_req = 1'b0;
    rst = 1'b0;
    step();
    check("rel_ready", 32'(cpu_wr_ready), 32'd1);

    // Single write reaches VRAM two edges after the push cycle
    drive_push(12'h123, 8'hA5);
    step();
    cpu_wr_valid = 1'b0;
    check("w1_count", 32'(fifo_count), 32'd1);
    check("w1_we_early", 32'(vram_we), 32'd0);
    step();
    check("w1_we", 32'(vram_we), 32'd1);
    check("w1_addr", 32'(vram_address), 32'h123);
    check("w1_data", 32'(vram_wdata), 32'hA5);
    check("w1_empty", 32'(fifo_count), 32'd0);
    step();
    check("w1_idle_we", 32'(vram_we), 32'd0);
    check("w1_idle_hold", 32'(vram_address), 32'h123);

    // GPU read: grant same cycle, data two cycles later, single-cycle valid
    gpu_rd_req = 1'b1;
    gpu_rd_address = 12'h040;
    #1;
    check("rd_grant", 32'(gpu_rd_grant), 32'd1);
    step();
    gpu_rd_req = 1'b0;
    check("rd_addr", 32'(vram_address), 32'h040);
    check("rd_we", 32'(vram_we), 32'd0);
    check("rd_valid_early", 32'(gpu_rd_valid), 32'd0);
    step();
    check("rd_valid", 32'(gpu_rd_valid), 32'd1);
    check("rd_data", 32'(gpu_rd_data), 32'h3C);
    step();
    check("rd_valid_drop", 32'(gpu_rd_valid), 32'd0);

    // Five pushes under constant GPU traffic: fifth dropped when full
    gpu_rd_req = 1'b1;
    gpu_rd_address = 12'h000;
    for (int i = 0; i < 5; i++) begin
      drive_push(12'h200 + 12'(i), 8'h10 + 8'(i));
      step();
    end
    cpu_wr_valid = 1'b0;
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready", 32'(cpu_wr_ready), 32'd0);
    gpu_rd_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check("drain_we", 32'(vram_we), 32'd1);
      check("drain_addr", 32'(vram_address), 32'h200 + 32'(j));
      check("drain_data", 32'(vram_wdata), 32'h10 + 32'(j));
    end
    step();
    check("drain_fifth_absent", 32'(vram_we), 32'd0);
    check("drain_count", 32'(fifo_count), 32'd0);

    // Simultaneous push and pop at count 2 keeps count and order
    gpu_rd_req = 1'b1;
    drive_push(12'h301, 8'h41);
    step();
    drive_push(12'h302, 8'h42);
    step();
    check("pp_pre_count", 32'(fifo_count), 32'd2);
    gpu_rd_req = 1'b0;
    drive_push(12'h303, 8'h43);
    step();
    cpu_wr_valid = 1'b0;
    check("pp_count", 32'(fifo_count), 32'd2);
    check("pp_first", 32'(vram_address), 32'h301);
    step();
    check("pp_second", 32'(vram_address), 32'h302);
    check("pp_second_data", 32'(vram_wdata), 32'h42);
    step();
    check("pp_third", 32'(vram_address), 32'h303);
    check("pp_end_count", 32'(fifo_count), 32'd0);

    // Constant GPU traffic with writes queued
    gpu_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_push(12'h400 + 12'(i), 8'h50 + 8'(i));
      step();
    end
    cpu_wr_valid = 1'b0;
    writes = 0;
    nogrant = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!gpu_rd_grant) nogrant++;
      step();
      if (vram_we) writes++;
    end
`ifdef VRAM_ARBITER_STARVE_GUARD_EN
    check("starve_writes", 32'(writes), 32'd3);
    check("starve_nogrant", 32'(nogrant), 32'd3);
    check("starve_count", 32'(fifo_count), 32'd0);
`else
    check("starve_writes", 32'(writes), 32'd0);
    check("starve_nogrant", 32'(nogrant), 32'd0);
    check("starve_count", 32'(fifo_count), 32'd3);
`endif
    gpu_rd_req = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("starve_drained", 32'(fifo_count), 32'd0);

    // Reset one cycle after a grant with three writes queued
    gpu_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_push(12'h500 + 12'(i), 8'h60 + 8'(i));
      step();
    end
    cpu_wr_valid = 1'b0;
    #1;
    check("mr_grant", 32'(gpu_rd_grant), 32'd1);
    check("mr_count", 32'(fifo_count), 32'd3);
    step();
    rst = 1'b1;
    #1;
    check("mr_count0", 32'(fifo_count), 32'd0);
    check("mr_we0", 32'(vram_we), 32'd0);
    check("mr_valid0", 32'(gpu_rd_valid), 32'd0);
    check("mr_grant0", 32'(gpu_rd_grant), 32'd0);
    step();
    check("mr_valid1", 32'(gpu_rd_valid), 32'd0);
    gpu_rd_req = 1'b0;
    rst = 1'b0;
    step();
    check("mr_ready", 32'(cpu_wr_ready), 32'd1);
    check("mr_valid2", 32'(gpu_rd_valid), 32'd0);
    step();
    check("mr_we2", 32'(vram_we), 32'd0);
    check("mr_count2", 32'(fifo_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
